// File: rtl/alarm_pkg.sv
// Shared state encoding and trigger-count constants for the alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXIT    = 3'd1,
    ARMED   = 3'd2,
    ENTRY   = 3'd3,
    ALARM   = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  localparam logic [3:0] TRIG_SAT = 4'd15;

  // Status display counter sticks at its maximum instead of wrapping.
  function automatic logic [3:0] satInc(input logic [3:0] value);
    return (value == TRIG_SAT) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/alarm_controller_delay_timer.sv
// Loadable down-counter shared by the exit, entry and siren delays.
module delay_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; the count holds at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_controller.sv
// Intrusion alarm FSM: exit delay, entry delay, window breach, timed siren and lockout.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int EXIT_DELAY  = 4,
  parameter int ENTRY_DELAY = 8,
  parameter int SIREN_TIME  = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       system_armed,
  input  logic       door,
  input  logic       window,
  output logic       alarm,
  output logic       entry_pending,
  output logic       monitoring,
  output logic [3:0] trigger_count,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

  state_t           state;
  state_t           nextState;
  logic             timerLoad;
  logic [CNT_W-1:0] timerLoadValue;
  logic             timerDec;
  logic             timerZero;
  logic             sensorsClosed;
  logic             enteringAlarm;

  assign sensorsClosed = door && window;
  assign enteringAlarm = (nextState == ALARM) && (state != ALARM);

  delay_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timerLoad),
    .load_value(timerLoadValue),
    .dec       (timerDec),
    .zero      (timerZero)
  );

  // Next-state and timer control; disarm beats every sensor and timer event.
  always_comb begin
    nextState      = state;
    timerLoad      = 1'b0;
    timerLoadValue = '0;
    timerDec       = 1'b0;

    case (state)
      IDLE: begin
        if (system_armed) begin
          nextState      = EXIT;
          timerLoad      = 1'b1;
          timerLoadValue = EXIT_LOAD;
        end
      end

      EXIT: begin
        if (!system_armed) begin
          nextState = IDLE;
        end else if (timerZero) begin
          nextState = ARMED;
        end else begin
          timerDec = 1'b1;
        end
      end

      ARMED: begin
        if (!system_armed) begin
          nextState = IDLE;
        end else if (!window) begin
          nextState      = ALARM;
          timerLoad      = 1'b1;
          timerLoadValue = SIREN_LOAD;
        end else if (!door) begin
          nextState      = ENTRY;
          timerLoad      = 1'b1;
          timerLoadValue = ENTRY_LOAD;
        end
      end

      ENTRY: begin
        if (!system_armed) begin
          nextState = IDLE;
        end else if (!window || timerZero) begin
          nextState      = ALARM;
          timerLoad      = 1'b1;
          timerLoadValue = SIREN_LOAD;
        end else begin
          timerDec = 1'b1;
        end
      end

      ALARM: begin
        if (!system_armed) begin
          nextState = IDLE;
        end else if (timerZero) begin
          nextState = sensorsClosed ? ARMED : LOCKOUT;
        end else begin
          timerDec = 1'b1;
        end
      end

      LOCKOUT: begin
        if (!system_armed) begin
          nextState = IDLE;
        end else if (sensorsClosed) begin
          nextState = ARMED;
        end
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      alarm         <= 1'b0;
      entry_pending <= 1'b0;
      monitoring    <= 1'b0;
      trigger_count <= '0;
    end else begin
      state         <= nextState;
      alarm         <= (nextState == ALARM);
      entry_pending <= (nextState == ENTRY);
      monitoring    <= (nextState == ARMED) || (nextState == ENTRY) ||
                       (nextState == ALARM) || (nextState == LOCKOUT);
      if (enteringAlarm) begin
        trigger_count <= satInc(trigger_count);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed table, corner sequences and random traffic
// compared against a time-in-state reference model.
module tb_alarm_controller;

  localparam int EXIT_DELAY  = 4;
  localparam int ENTRY_DELAY = 8;
  localparam int SIREN_TIME  = 16;
  localparam int CNT_W       = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       system_armed = 1'b0;
  logic       door = 1'b1;
  logic       window = 1'b1;
  logic       alarm;
  logic       entry_pending;
  logic       monitoring;
  logic [3:0] trigger_count;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;

  // Reference model: phase code, cycles spent in the phase, trigger tally.
  int mPhase = 0;
  int mTime = 0;
  int mCount = 0;

  typedef struct {
    logic       rst;
    logic       armed;
    logic       door;
    logic       window;
    logic [2:0] st;
    logic       alarm;
    logic       entry;
    logic       mon;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  alarm_controller #(
    .EXIT_DELAY (EXIT_DELAY),
    .ENTRY_DELAY(ENTRY_DELAY),
    .SIREN_TIME (SIREN_TIME),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .system_armed (system_armed),
    .door         (door),
    .window       (window),
    .alarm        (alarm),
    .entry_pending(entry_pending),
    .monitoring   (monitoring),
    .trigger_count(trigger_count),
    .state_dbg    (state_dbg)
  );

  // Phases: 0 idle, 1 exit, 2 armed, 3 entry, 4 alarm, 5 lockout.
  function automatic void stepModel(input logic r, input logic a, input logic d, input logic w);
    int np;
    if (!r) begin
      mPhase = 0;
      mTime  = 0;
      mCount = 0;
      return;
    end
    np = mPhase;
    if (mPhase == 0) begin
      if (a) np = 1;
    end else if (!a) begin
      np = 0;
    end else begin
      case (mPhase)
        1: if (mTime >= EXIT_DELAY) np = 2;
        2: if (!w) np = 4; else if (!d) np = 3;
        3: if (!w || mTime >= ENTRY_DELAY) np = 4;
        4: if (mTime >= SIREN_TIME) np = (d && w) ? 2 : 5;
        5: if (d && w) np = 2;
        default: np = 0;
      endcase
    end
    if (np == 4 && mPhase != 4 && mCount < 15) mCount++;
    mTime  = (np != mPhase) ? 1 : mTime + 1;
    mPhase = np;
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycleNo, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a, input logic d, input logic w);
    reset        = r;
    system_armed = a;
    door         = d;
    window       = w;
    @(posedge clk);
    stepModel(r, a, d, w);
    cycleNo++;
    #1;
  endtask

  task automatic checkOutput(input string tag, input int st, input int al, input int en,
                             input int mo, input int cn);
    checkVal({tag, ".state"}, int'(state_dbg), st);
    checkVal({tag, ".alarm"}, int'(alarm), al);
    checkVal({tag, ".entry"}, int'(entry_pending), en);
    checkVal({tag, ".monitoring"}, int'(monitoring), mo);
    checkVal({tag, ".count"}, int'(trigger_count), cn);
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, mPhase, int'(mPhase == 4), int'(mPhase == 3),
                int'(mPhase >= 2 && mPhase <= 5), mCount);
  endtask

  task automatic cycle(input logic r, input logic a, input logic d, input logic w, input string tag);
    applyStimulus(r, a, d, w);
    checkModel(tag);
  endtask

  // Brings the controller from IDLE through the full exit delay into ARMED.
  task automatic armUp(input string tag);
    for (int i = 0; i <= EXIT_DELAY; i++) cycle(1, 1, 1, 1, tag);
    checkVal({tag, ".armed"}, int'(state_dbg), 2);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog cycle=%0d actual=timeout expected=finish", cycleNo);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int entryCycles;
    int alarmCycles;
    int sawAlarm;
    logic r, a, d, w;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 4'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 4'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].armed, vecs[i].door, vecs[i].window);
      checkOutput($sformatf("table%0d", i), vecs[i].st, vecs[i].alarm, vecs[i].entry,
                  vecs[i].mon, vecs[i].cnt);
    end

    // Entry timeout: one-cycle door opening, then 8 entry cycles and 16 siren cycles.
    cycle(0, 0, 1, 1, "entryRst");
    armUp("entryArm");
    entryCycles = 0;
    alarmCycles = 0;
    cycle(1, 1, 0, 1, "entryOpen");
    if (entry_pending) entryCycles++;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 1, 1, "entryRun");
      if (entry_pending) entryCycles++;
      if (alarm) alarmCycles++;
    end
    checkVal("entryTimeout.entryCycles", entryCycles, ENTRY_DELAY);
    checkVal("entryTimeout.alarmCycles", alarmCycles, SIREN_TIME);
    checkVal("entryTimeout.count", int'(trigger_count), 1);
    checkVal("entryTimeout.final", int'(state_dbg), 2);

    // Entry disarm after three entry cycles.
    sawAlarm = 0;
    cycle(1, 1, 0, 1, "disarmOpen");
    cycle(1, 1, 1, 1, "disarmWait");
    cycle(1, 1, 1, 1, "disarmWait");
    if (alarm) sawAlarm = 1;
    cycle(1, 0, 1, 1, "disarmDrop");
    if (alarm) sawAlarm = 1;
    checkVal("entryDisarm.state", int'(state_dbg), 0);
    checkVal("entryDisarm.sawAlarm", sawAlarm, 0);
    checkVal("entryDisarm.count", int'(trigger_count), 1);

    // Door and window open together: window wins, then lockout while held open.
    armUp("prioArm");
    cycle(1, 1, 0, 0, "prioBoth");
    checkVal("windowPriority.state", int'(state_dbg), 4);
    alarmCycles = int'(alarm);
    for (int i = 0; i < 19; i++) begin
      cycle(1, 1, 0, 0, "prioHold");
      if (alarm) alarmCycles++;
    end
    checkVal("lockout.alarmCycles", alarmCycles, SIREN_TIME);
    checkVal("lockout.state", int'(state_dbg), 5);
    checkVal("lockout.alarm", int'(alarm), 0);
    cycle(1, 1, 1, 1, "lockoutClose");
    checkVal("lockoutClose.state", int'(state_dbg), 2);
    checkVal("lockoutClose.count", int'(trigger_count), 2);

    // Window open through the exit delay: ignored until the first armed cycle.
    cycle(1, 0, 1, 1, "exitDisarm");
    sawAlarm = 0;
    for (int i = 0; i < EXIT_DELAY; i++) begin
      cycle(1, 1, 1, 0, "exitWindow");
      if (alarm) sawAlarm = 1;
    end
    checkVal("exitSensors.sawAlarm", sawAlarm, 0);
    cycle(1, 1, 1, 0, "exitToArmed");
    checkVal("exitSensors.armed", int'(state_dbg), 2);
    cycle(1, 1, 1, 0, "exitBreach");
    checkVal("exitSensors.alarmState", int'(state_dbg), 4);
    checkVal("exitSensors.alarm", int'(alarm), 1);

    // Seventeen window triggers saturate the count, then reset lands mid-alarm.
    cycle(0, 0, 1, 1, "satRst");
    for (int t = 0; t < 17; t++) begin
      cycle(1, 0, 1, 1, "satDisarm");
      armUp("satArm");
      cycle(1, 1, 1, 0, "satTrigger");
    end
    checkVal("saturation.count", int'(trigger_count), 15);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, "satAlarm");
    checkVal("saturation.inAlarm", int'(state_dbg), 4);
    applyStimulus(0, 1, 1, 1);
    checkOutput("resetMidAlarm", 0, 0, 0, 0, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      a = ($urandom_range(0, 99) != 0);
      d = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 29) != 0);
      cycle(r, a, d, w, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Consumes `system_armed` from the password/arming FSM, together with the raw door and window contact sensors.
- Drives the siren output `alarm`.
- Adds an exit delay after arming, an entry delay on door opening, immediate alarm on window breach, a timed siren, and a lockout while a breach persists.
- Keeps a saturating count of alarm triggers for the status display.

Parameters:
- EXIT_DELAY, 4, cycles after arming during which sensors are ignored (range 1..2^CNT_W-1)
- ENTRY_DELAY, 8, cycles from door opening to alarm (range 1..2^CNT_W-1)
- SIREN_TIME, 16, cycles the alarm output stays high per trigger (range 1..2^CNT_W-1)
- CNT_W, 8, width of the shared delay counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- system_armed  input  1  1 = armed request from the arming FSM
- door  input  1  door contact, 0 = open
- window  input  1  window contact, 0 = open
- alarm  output  1  siren drive, high only in ALARM
- entry_pending  output  1  high only in ENTRY (keypad beeper)
- monitoring  output  1  high in ARMED, ENTRY, ALARM, LOCKOUT
- trigger_count  output  4  saturating count of ALARM entries
- state_dbg  output  3  current state code

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, counter=0, all outputs 0, trigger_count=0.
  - Reset overrides everything, including mid-ALARM and mid-delay.
- All outputs are registered and update on the same edge as the state register. No combinational path from inputs to outputs.
- Disarm priority: in every state except IDLE, system_armed==0 sends the FSM to IDLE on the next edge. This overrides sensor and timer events in the same cycle.
- IDLE:
  - system_armed==1 -> EXIT; counter loads EXIT_DELAY-1.
- EXIT:
  - Sensors ignored.
  - counter==0 -> ARMED; otherwise decrement.
  - Net effect: EXIT lasts exactly EXIT_DELAY cycles.
- ARMED:
  - window==0 -> ALARM; counter loads SIREN_TIME-1.
  - Else door==0 -> ENTRY; counter loads ENTRY_DELAY-1.
  - Else stay.
  - If window and door are both open in the same cycle, window wins (ALARM).
- ENTRY:
  - window==0 -> ALARM immediately (counter loads SIREN_TIME-1).
  - Else counter==0 -> ALARM.
  - Else decrement.
  - Closing the door does not cancel ENTRY; only disarm does.
- ALARM:
  - counter==0 -> ARMED if door==1 and window==1, else LOCKOUT.
  - Otherwise decrement.
  - Sensor changes during ALARM do not restart the timer.
- LOCKOUT:
  - alarm=0. Stays until door==1 and window==1, then -> ARMED.
  - There is no re-trigger from LOCKOUT.
- trigger_count:
  - +1 on every transition into ALARM; saturates at 15.
  - Cleared only by reset; disarm does not clear it.
- Counter:
  - CNT_W bits, down-count only.
  - Loads happen on the transition edge. Delays are measured in cycles spent in the state.
- Illegal state codes -> IDLE on the next edge, outputs 0.

Decomposition:
- Package alarm_pkg holds:
  - state encoding: IDLE=3'd0, EXIT=3'd1, ARMED=3'd2, ENTRY=3'd3, ALARM=3'd4, LOCKOUT=3'd5
  - trigger-count saturation constant 4'd15
- One sub-module, delay_timer:
  - loadable CNT_W down-counter with load, load_value, dec and zero flag
  - same clk and reset (synchronous, active-low)
- The FSM stays in alarm_controller.

Test Plan:
- Reset then arm: reset low 2 cycles, raise system_armed at edge 0 -> state_dbg=1 for edges 1..4, state_dbg=2 at edge 5, monitoring=1 from edge 5, alarm=0 throughout.
- Entry timeout: armed, door=0 for one cycle then door=1 -> entry_pending high 8 cycles, then alarm high exactly 16 cycles, trigger_count=1, then state ARMED.
- Entry disarm: door=0, drop system_armed after 3 ENTRY cycles -> IDLE next edge, alarm never asserts, trigger_count unchanged.
- Window priority and lockout: in ARMED, door=0 and window=0 same cycle, held open -> ALARM next edge (not ENTRY), alarm 16 cycles, then LOCKOUT with alarm=0. Close both sensors -> ARMED next edge.
- Sensors during EXIT: window=0 throughout EXIT -> no alarm during EXIT; ALARM on the first cycle in ARMED if window is still 0.
- Saturation and reset mid-alarm: 17 window triggers (disarm/re-arm between) -> trigger_count=15. Assert reset during ALARM -> next edge: alarm=0, state_dbg=0, trigger_count=0.
